// File: rtl/xf100_biu_arb_pkg.sv
// Shared types and defaults for the xf100 bus interface arbiter.
package xf100_biu_arb_pkg;

    localparam int XF100_PC_SIZE        = 32;
    localparam int XF100_INSTR_SIZE     = 32;
    localparam int XF100_BIU_TIMEOUT    = 256;
    localparam int XF100_ARB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        XF100_ARB_IDLE = 2'd0,
        XF100_ARB_REQ  = 2'd1,
        XF100_ARB_RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        XF100_ARB_OWNER_IFU = 1'b0,
        XF100_ARB_OWNER_LSU = 1'b1
    } arb_owner_e;

    // LSU has priority, except when IFU has been passed over too many times.
    function automatic logic arb_pick_ifu(input logic ifu_v, input logic lsu_v, input logic starved);
        return ifu_v && (!lsu_v || starved);
    endfunction

endpackage

// File: rtl/xf100_biu_wdog.sv
// Response watchdog: clearable, enabled counter flagging expiry at TIMEOUT-1.
module xf100_biu_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xf100_biu_arb.sv
// Shares one memory port between IFU and LSU: one transaction in flight,
// grant -> memory request -> response routed to the owner, with a timeout.
module xf100_biu_arb
    import xf100_biu_arb_pkg::*;
#(
    parameter int ADDR_W     = XF100_PC_SIZE,
    parameter int DATA_W     = XF100_INSTR_SIZE,
    parameter int STARVE_MAX = XF100_ARB_STARVE_MAX,
    parameter int TIMEOUT    = XF100_BIU_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    input  logic                mem_rsp_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    arb_owner_e          r_owner;
    logic [SW-1:0]       r_starve;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;
    logic                r_ifu_rsp_valid, r_ifu_rsp_err;
    logic                r_lsu_rsp_valid, r_lsu_rsp_err;
    logic [DATA_W-1:0]   r_ifu_rsp_rdata, r_lsu_rsp_rdata;
    logic                w_ifu_win, w_lsu_win, w_accept, w_rsp_fire, w_expired;
    logic [DATA_W-1:0]   w_rsp_rdata;
    logic                w_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= XF100_ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ifu_win   = 1'b0;
        w_lsu_win   = 1'b0;
        w_accept    = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            XF100_ARB_IDLE: begin
                w_ifu_win = arb_pick_ifu(ifu_req_valid, lsu_req_valid,
                                         r_starve == SW'(STARVE_MAX));
                w_lsu_win = lsu_req_valid && !w_ifu_win;
                if (w_ifu_win || w_lsu_win) begin
                    w_state_nxt = XF100_ARB_REQ;
                end
            end
            XF100_ARB_REQ: begin
                if (mem_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = XF100_ARB_RSP;
                end
            end
            XF100_ARB_RSP: begin
                // A real response in the expiry cycle takes precedence.
                if (mem_rsp_valid || w_expired) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = XF100_ARB_IDLE;
                end
            end
            default: w_state_nxt = XF100_ARB_IDLE;
        endcase
    end

    assign ifu_req_ready = w_ifu_win;
    assign lsu_req_ready = w_lsu_win;
    assign mem_req_valid = (r_state == XF100_ARB_REQ);
    assign mem_req_addr  = r_addr;
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= XF100_ARB_OWNER_IFU;
            r_starve <= '0;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
        end else if (w_ifu_win) begin
            r_owner  <= XF100_ARB_OWNER_IFU;
            r_starve <= '0;
            r_addr   <= ifu_req_addr;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
        end else if (w_lsu_win) begin
            r_owner  <= XF100_ARB_OWNER_LSU;
            r_addr   <= lsu_req_addr;
            r_wen    <= lsu_req_wen;
            r_wdata  <= lsu_req_wdata;
            r_wmask  <= lsu_req_wmask;
            if (ifu_req_valid && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    xf100_biu_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_accept),
        .i_en      (r_state == XF100_ARB_RSP),
        .o_expired (w_expired)
    );

    assign w_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : '0;
    assign w_rsp_err   = mem_rsp_valid ? mem_rsp_err : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_rdata <= '0;
            r_ifu_rsp_err   <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_rdata <= '0;
            r_lsu_rsp_err   <= 1'b0;
        end else begin
            r_ifu_rsp_valid <= w_rsp_fire && (r_owner == XF100_ARB_OWNER_IFU);
            r_lsu_rsp_valid <= w_rsp_fire && (r_owner == XF100_ARB_OWNER_LSU);
            if (w_rsp_fire && (r_owner == XF100_ARB_OWNER_IFU)) begin
                r_ifu_rsp_rdata <= w_rsp_rdata;
                r_ifu_rsp_err   <= w_rsp_err;
            end
            if (w_rsp_fire && (r_owner == XF100_ARB_OWNER_LSU)) begin
                r_lsu_rsp_rdata <= w_rsp_rdata;
                r_lsu_rsp_err   <= w_rsp_err;
            end
        end
    end

    assign ifu_rsp_valid = r_ifu_rsp_valid;
    assign ifu_rsp_rdata = r_ifu_rsp_rdata;
    assign ifu_rsp_err   = r_ifu_rsp_err;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign lsu_rsp_rdata = r_lsu_rsp_rdata;
    assign lsu_rsp_err   = r_lsu_rsp_err;

endmodule
